// File: rtl/jesd_sysref_gen_if.sv
// Bundles the SYSREF generator's config, start/stop handshake and status outputs.
// Master drives config and requests; slave (the generator) drives status and SYSREF.
interface jesd_sysref_gen_if #(
  parameter int LMFC_W = 10,
  parameter int PLEN_W = 4,
  parameter int CNT_W  = 8
);
  logic [LMFC_W-1:0] cfg_lmfc_period;
  logic [PLEN_W-1:0] cfg_pulse_len;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_num_pulses;
  logic              start;
  logic              stop;
  logic              lmfc_tick;
  logic              sysref_out;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  pulse_cnt;

  modport master (
    output cfg_lmfc_period, cfg_pulse_len, cfg_mode, cfg_num_pulses, start, stop,
    input  lmfc_tick, sysref_out, busy, done, pulse_cnt
  );

  modport slave (
    input  cfg_lmfc_period, cfg_pulse_len, cfg_mode, cfg_num_pulses, start, stop,
    output lmfc_tick, sysref_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/jesd_sysref_gen.sv
// LMFC-aligned JESD204 SYSREF generator (continuous / gapped / one-shot); JESD_SYSREF_DIFF_OUT_EN adds a pad pair.
// Latency: first SYSREF edge on the first LMFC tick after start; pad outputs lag sysref_out by one cycle.
// Backpressure: none; start is dropped unless idle, stop is honoured only at pulse boundaries.
module jesd_sysref_gen #(
  parameter int LMFC_W = 10,
  parameter int PLEN_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic               coreclk,
  input  logic               rst_n,
  jesd_sysref_gen_if.slave   bus
`ifdef JESD_SYSREF_DIFF_OUT_EN
  ,
  output logic               sysref_pad_p,
  output logic               sysref_pad_n
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_PULSE, S_GAP, S_FINISH} state_t;
  typedef enum logic [1:0] {M_OFF = 2'b00, M_CONT = 2'b01, M_GAPD = 2'b10, M_ONE = 2'b11} mode_t;

  state_t            state, state_nxt;
  mode_t             mode_q;
  logic [LMFC_W-1:0] lmfc_cnt, cnt_nxt, p_eff, len_ext, len_eff;
  logic              tick_nxt, tick_q;
  logic [PLEN_W-1:0] len_q, len_cnt;
  logic [CNT_W-1:0]  num_q, pulse_cnt_q;
  logic              stop_pend, accept, pulse_end, more;
  logic              sysref_q, busy_q, done_q;

  always_comb begin
    p_eff    = (bus.cfg_lmfc_period < LMFC_W'(2)) ? LMFC_W'(2) : bus.cfg_lmfc_period;
    cnt_nxt  = (lmfc_cnt >= p_eff - LMFC_W'(1)) ? '0 : lmfc_cnt + LMFC_W'(1);
    tick_nxt = (cnt_nxt == '0);
    len_ext  = LMFC_W'(bus.cfg_pulse_len);
    // Keep at least one low cycle per period so a continuous train never merges pulses.
    len_eff  = (len_ext == '0) ? LMFC_W'(1) :
               (len_ext >= p_eff) ? p_eff - LMFC_W'(1) : len_ext;
  end

  assign accept    = (state == S_IDLE) && (bus.cfg_mode != 2'b00) && bus.start && !bus.stop;
  assign pulse_end = (len_cnt == len_q);
  assign more      = (mode_q == M_CONT) || ((mode_q == M_GAPD) && (pulse_cnt_q < num_q));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ARM;
      S_ARM:    if (bus.stop) state_nxt = S_FINISH;
                else if (tick_nxt) state_nxt = S_PULSE;
      S_PULSE:  if (pulse_end) state_nxt = (bus.stop || stop_pend || !more) ? S_FINISH : S_GAP;
      S_GAP:    if (bus.stop) state_nxt = S_FINISH;
                else if (tick_nxt) state_nxt = more ? S_PULSE : S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lmfc_cnt    <= '0;
      tick_q      <= 1'b0;
      sysref_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= M_OFF;
      len_q       <= '0;
      len_cnt     <= '0;
      num_q       <= '0;
      pulse_cnt_q <= '0;
      stop_pend   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lmfc_cnt <= cnt_nxt;
      tick_q   <= tick_nxt;
      // Outputs decode the next state so the first high cycle lands on the tick cycle.
      sysref_q <= (state_nxt == S_PULSE);
      busy_q   <= (state_nxt == S_ARM) || (state_nxt == S_PULSE) || (state_nxt == S_GAP);
      done_q   <= (state_nxt == S_FINISH);

      if (accept) begin
        mode_q      <= mode_t'(bus.cfg_mode);
        len_q       <= PLEN_W'(len_eff);
        num_q       <= (bus.cfg_num_pulses == '0) ? CNT_W'(1) : bus.cfg_num_pulses;
        pulse_cnt_q <= '0;
        stop_pend   <= 1'b0;
      end else if ((state_nxt == S_PULSE) && (state != S_PULSE) && (pulse_cnt_q != '1)) begin
        pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
      end

      if (state_nxt == S_PULSE)
        len_cnt <= (state == S_PULSE) ? len_cnt + PLEN_W'(1) : PLEN_W'(1);

      if ((state == S_PULSE) && bus.stop)
        stop_pend <= 1'b1;
    end
  end

  assign bus.lmfc_tick  = tick_q;
  assign bus.sysref_out = sysref_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulse_cnt  = pulse_cnt_q;

`ifdef JESD_SYSREF_DIFF_OUT_EN
  logic pad_q;

  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) pad_q <= 1'b0;
    else        pad_q <= sysref_q;
  end

  assign sysref_pad_p = pad_q;
  assign sysref_pad_n = ~pad_q;
`endif

endmodule

// File: tb/tb_jesd_sysref_gen.sv
// Directed bench for jesd_sysref_gen: a negedge monitor measures each sequence and scores it
// against an expected-sequence queue filled by the stimulus before every start.
module tb_jesd_sysref_gen;
  localparam int LMFC_W = 10;
  localparam int PLEN_W = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jesd_sysref_gen_if #(.LMFC_W(LMFC_W), .PLEN_W(PLEN_W), .CNT_W(CNT_W)) bus();

`ifdef JESD_SYSREF_DIFF_OUT_EN
  logic pad_p, pad_n;
`endif

  jesd_sysref_gen #(.LMFC_W(LMFC_W), .PLEN_W(PLEN_W), .CNT_W(CNT_W)) dut (
    .coreclk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef JESD_SYSREF_DIFF_OUT_EN
    ,
    .sysref_pad_p (pad_p),
    .sysref_pad_n (pad_n)
`endif
  );

  typedef struct {
    int pulses;
    int width;
    int pcnt;
    int lat;
    int per;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: per-sequence measurements, scored on each done pulse
  int   m_cyc, m_pulses, m_w, m_wmin, m_wmax, m_lat, m_last, m_spmin, m_spmax, m_mis, m_sp;
  logic p_sys = 1'b0;
  logic p_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_sys  = 1'b0;
      p_busy = 1'b0;
    end else begin
      if (bus.busy && !p_busy) begin
        m_cyc = 0; m_pulses = 0; m_w = 0; m_lat = -1; m_last = 0; m_mis = 0;
        m_wmin = 1 << 30; m_wmax = 0; m_spmin = 1 << 30; m_spmax = 0;
      end else begin
        m_cyc++;
      end
      if (bus.sysref_out && !p_sys) begin
        m_pulses++;
        if (!bus.lmfc_tick) m_mis++;
        if (m_pulses == 1) m_lat = m_cyc;
        else begin
          m_sp = m_cyc - m_last;
          if (m_sp < m_spmin) m_spmin = m_sp;
          if (m_sp > m_spmax) m_spmax = m_sp;
        end
        m_last = m_cyc;
        m_w = 1;
      end else if (bus.sysref_out) begin
        m_w++;
      end
      if (!bus.sysref_out && p_sys) begin
        if (m_w < m_wmin) m_wmin = m_w;
        if (m_w > m_wmax) m_wmax = m_w;
      end
      if (bus.done) begin
        chk("done_has_expected_seq", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("num_pulses", m_pulses, e.pulses);
          chk("width_min", m_wmin, e.width);
          chk("width_max", m_wmax, e.width);
          chk("pulse_cnt_at_done", int'(bus.pulse_cnt), e.pcnt);
          chk("start_to_first_pulse", m_lat, e.lat);
          chk("pulse_off_tick", m_mis, 0);
          chk("busy_low_at_done", int'(bus.busy), 0);
          chk("sysref_fell_at_done", int'(p_sys), 1);
          if (e.per > 0) begin
            chk("spacing_min", m_spmin, e.per);
            chk("spacing_max", m_spmax, e.per);
          end
        end
      end
      p_sys  = bus.sysref_out;
      p_busy = bus.busy;
    end
  end

`ifdef JESD_SYSREF_DIFF_OUT_EN
  logic d_prev = 1'b0;
  logic d_ok = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) d_ok = 1'b0;
    else begin
      if (d_ok) begin
        chk("pad_p_delayed", int'(pad_p), int'(d_prev));
        chk("pad_n_complement", int'(pad_n ^ pad_p), 1);
      end
      d_prev = bus.sysref_out;
      d_ok   = 1'b1;
    end
  end
`endif

  task automatic set_cfg(input int p, input int l, input int mode, input int n);
    bus.cfg_lmfc_period = LMFC_W'(p);
    bus.cfg_pulse_len   = PLEN_W'(l);
    bus.cfg_mode        = 2'(mode);
    bus.cfg_num_pulses  = CNT_W'(n);
  endtask

  task automatic wait_tick();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.lmfc_tick) begin ok = 1'b1; break; end
    end
    chk("tick_found", int'(ok), 1);
  endtask

  // start is held high during the cycle whose lmfc_cnt equals c
  task automatic start_at(input int c);
    wait_tick();
    repeat (c) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1; break; end
    end
    chk("done_within_budget", seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, cnt, found;
    logic ps;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(16, 4, 3, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sysref", int'(bus.sysref_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pulse_cnt", int'(bus.pulse_cnt), 0);
    chk("rst_lmfc_tick", int'(bus.lmfc_tick), 0);
    rst_n = 1'b1;

    // one-shot, P=16 L=4, start at lmfc_cnt=5
    set_cfg(16, 4, 3, 1);
    sb.push_back('{pulses:1, width:4, pcnt:1, lat:10, per:0});
    start_at(5);
    wait_done(60);
    repeat (5) @(negedge clk);
    chk("pulse_cnt_hold", int'(bus.pulse_cnt), 1);

    // gapped, P=10 L=3 N=3
    set_cfg(10, 3, 2, 3);
    sb.push_back('{pulses:3, width:3, pcnt:3, lat:7, per:10});
    start_at(2);
    wait_done(100);

    // continuous, P=8 L=2, stop in second high cycle of pulse 5
    set_cfg(8, 2, 1, 0);
    sb.push_back('{pulses:5, width:2, pcnt:5, lat:4, per:8});
    start_at(3);
    rises = 0;
    ps = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.sysref_out && !ps) rises++;
      ps = bus.sysref_out;
      if (rises == 5) break;
    end
    chk("cont_reached_pulse5", rises, 5);
    @(negedge clk);
    bus.stop = 1'b1;
    wait_done(20);
    bus.stop = 1'b0;
    repeat (20) @(negedge clk);
    chk("cont_no_pulse6", int'(bus.busy), 0);

    // P=1 -> 2-cycle ticks; L=0 -> 1 cycle; N=0 -> 1 pulse
    set_cfg(1, 0, 2, 0);
    wait_tick();
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(bus.lmfc_tick);
    end
    chk("p1_tick_count", cnt, 10);
    sb.push_back('{pulses:1, width:1, pcnt:1, lat:1, per:0});
    start_at(0);
    wait_done(20);

    // L=12 with P=8 -> 7-cycle pulse
    set_cfg(8, 12, 3, 1);
    sb.push_back('{pulses:1, width:7, pcnt:1, lat:6, per:0});
    start_at(1);
    wait_done(40);

    // start on a tick cycle: pulse lands on the following tick
    set_cfg(10, 2, 3, 1);
    sb.push_back('{pulses:1, width:2, pcnt:1, lat:9, per:0});
    start_at(0);
    wait_done(40);

    // start + stop together in IDLE: nothing happens
    wait_tick();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      cnt += int'(bus.busy);
    end
    chk("start_stop_idle_busy", cnt, 0);

    // start and config changes while busy are ignored
    set_cfg(8, 2, 2, 2);
    sb.push_back('{pulses:2, width:2, pcnt:2, lat:6, per:8});
    start_at(1);
    repeat (3) @(negedge clk);
    set_cfg(8, 5, 1, 7);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(60);
    repeat (20) @(negedge clk);
    chk("busy_start_not_queued", int'(bus.busy), 0);

    // reset mid-pulse: sysref drops at once, no done
    set_cfg(8, 4, 1, 0);
    start_at(0);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.sysref_out) begin found = 1; break; end
    end
    chk("rst_test_pulse_seen", found, 1);
    @(negedge clk);
    chk("pre_reset_sysref", int'(bus.sysref_out), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_sysref", int'(bus.sysref_out), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_pulse_cnt", int'(bus.pulse_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(bus.done);
    end
    chk("no_done_after_reset", cnt, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
